ex_muldiv: RTL
==============

# ex_muldiv

Parametrised execute stage for the RV32I pipeline: single-cycle ALU, branch and jump resolution for the full RV32I integer set, plus an iterative RV32M multiply/divide unit. It sits between id_ex and the register file / control block, and asserts hold_flag_o to stall the pipeline while a multi-cycle M operation runs. Loads, stores, FENCE and SYSTEM are resolved elsewhere; this block drives zero outputs for them.

## Interface
- XLEN, 32: datapath width for operands, PC and results.
- MUL_BITS, 2: multiplier bits retired per cycle; must divide XLEN.
- M_EN, 1: 0 removes the M unit, and M opcodes produce zero outputs with no hold.

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- inst_i  in  32  instruction in EX
- inst_addr_i  in  XLEN  PC of inst_i
- op1_i  in  XLEN  rs1 for R/I/B/JALR; the immediate for LUI/AUIPC/JAL
- op2_i  in  XLEN  rs2 for R/B; the immediate for I-type/JALR
- rd_addr_i  in  5  destination register
- rd_wen_i  in  1  decode write-enable (for legal instructions, ignored in favour of the opcode decode)
- rd_addr_o  out  5  writeback address
- rd_data_o  out  XLEN  writeback data
- rd_wen_o  out  1  writeback strobe; forced 0 when rd_addr_i==0
- jump_addr_o  out  XLEN  redirect target; 0 when jump_en_o=0
- jump_en_o  out  1  redirect request
- hold_flag_o  out  1  pipeline stall request

## Operation
- Single-cycle group (combinational, hold=0):
  - ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND and their immediate forms. Shift amount is op2_i[$clog2(XLEN)-1:0].
  - LUI gives op1_i.
  - AUIPC gives inst_addr_i+op1_i.
  - JAL: rd=inst_addr_i+4, target inst_addr_i+op1_i.
  - JALR: rd=inst_addr_i+4, target (op1_i+op2_i)&~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: target inst_addr_i+B-imm (decoded from inst_i), driven only when taken.
- M group: opcode 0110011 with funct7 0000001.
- FSM states:
  - IDLE: a decoded M op combinationally raises hold=1 and latches operand magnitudes, the result-negate flag, the op type and rd.
    - Normal case: next state BUSY, counter cleared.
    - Div-by-zero or signed overflow: next state DONE, with the result preloaded.
  - BUSY: hold=1.
    - Multiply: shift-add of MUL_BITS bits per cycle for XLEN/MUL_BITS cycles, accumulating a 2·XLEN unsigned product.
    - Divide: restoring division, 1 bit per cycle for XLEN cycles.
    - Transition to DONE on the last count.
  - DONE: hold=0, rd_wen_o=1, rd_addr_o=latched rd, rd_data_o=final result. Next state is IDLE unconditionally.
- Result selection and sign fixup:
  - MUL takes the low half of the product; MULH, MULHSU and MULHU take the high half.
  - Operands are converted to magnitudes according to signedness. The product is negated (2·XLEN two's complement) when the operand signs differ.
  - The quotient is negated when the signs differ. The remainder takes the dividend's sign.
- Special cases:
  - Divide by zero: quotient all-ones, remainder = dividend.
  - DIV/REM of -2^(XLEN-1) by -1: quotient = dividend, remainder 0.
- While hold=1, inst_i and the operands are held stable by control. The block uses its latched copies regardless.
- Back-to-back M ops: the DONE cycle retires the first op, and the next op is accepted in the following IDLE cycle with no bubble.

## Timing
- Reset (rst_n=0, at any time including mid-BUSY):
  - FSM goes to IDLE.
  - Counter, accumulator and result registers clear.
  - All outputs are 0 while reset is asserted: rd_addr_o, rd_data_o, rd_wen_o, jump_addr_o, jump_en_o, hold_flag_o.
  - An interrupted op never writes back.
- Single-cycle ops: outputs are valid in the same cycle inst_i is presented; hold stays 0.
- Multiply: hold is high for 1+XLEN/MUL_BITS cycles (17 at defaults). The result appears the next cycle, in DONE.
- Divide: hold is high for 1+XLEN cycles (33). The result appears in DONE.
- Special-case divide: hold is high for 1 cycle, then DONE.
- In IDLE and BUSY the writeback outputs are 0; writeback occurs only in the DONE cycle.
- jump_en_o is never asserted together with hold_flag_o.

## Test plan
- Single-cycle ALU and jump, defaults:
  - SRAI with op1=0xFFFF_FFF0, shift 2 -> rd_data 0xFFFF_FFFC, rd_wen=1, hold=0 in the same cycle.
  - JALR with op1=0x203, op2=4, pc=0x100 -> jump_en=1, jump_addr 0x206, rd_data 0x104.
- Branches, pc=0x100, B-imm=0x20, op1=0xFFFF_FFFF, op2=1:
  - BLT -> jump_en=1, jump_addr 0x120.
  - BGEU -> jump_en=1, jump_addr 0x120.
  - BLTU -> jump_en=0, jump_addr 0.
- Multiply:
  - MUL 7×0xFFFF_FFFD -> hold for 17 cycles, then a single rd_wen pulse with 0xFFFF_FFEB.
  - MULH 0x8000_0000×0x8000_0000 -> 0x4000_0000.
  - MULHU 0xFFFF_FFFF×2 -> 1.
- Divide:
  - DIV 0xFFFF_FFF9/2 -> hold for 33 cycles, result 0xFFFF_FFFD.
  - REM with the same operands -> 0xFFFF_FFFF.
  - DIVU 100/7 -> 14.
- Divide special cases (2-cycle latency):
  - DIVU 5/0 -> 0xFFFF_FFFF.
  - REM 5/0 -> 5.
  - DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000.
  - REM with the same operands -> 0.
- Reset and back-to-back:
  - rst_n pulsed low at BUSY cycle 10 of a DIV -> all outputs 0 immediately, no writeback. After release, an ADD 3+4 writes 7 in one cycle.
  - MUL followed directly by DIVU -> two rd_wen pulses, 34 cycles apart.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: RV32I execute stage (ALU, branch, jump) with an iterative RV32M multiply/divide unit
// Ports: clk/rst_n (async active-low); inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, rd_wen_i from id_ex;
// rd_addr_o/rd_data_o/rd_wen_o writeback; jump_addr_o/jump_en_o redirect; hold_flag_o pipeline stall.
module ex_muldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 2,
  parameter int M_EN     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_wen_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            jump_en_o,
  output logic            hold_flag_o
);
  localparam int SW = $clog2(XLEN);
  localparam int W2 = 2 * XLEN;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          r_state;
  logic [SW-1:0]   r_cnt;
  logic [W2-1:0]   r_acc, r_a;
  logic [XLEN-1:0] r_b, r_res;
  logic [2:0]      r_f3;
  logic            r_neg;
  logic [4:0]      r_rd;
  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic            w_is_op, w_is_m, w_sub, w_eq, w_lt, w_ltu, w_take;
  logic [SW-1:0]   w_sh;
  logic [XLEN-1:0] w_sra, w_alu, w_bimm, w_pc4, w_jalr;
  logic            w_wen, w_jen;
  logic [XLEN-1:0] w_data, w_jaddr;
  logic            w_s1, w_s2, w_n1, w_n2, w_dz, w_ovf, w_rneg;
  logic [XLEN-1:0] w_m1, w_m2, w_spec;
  logic [W2-1:0]   w_mstep, w_dstep, w_acc_n, w_p;
  logic [XLEN:0]   w_dsh, w_dsub;
  logic [XLEN-1:0] w_v, w_fin;
  logic            w_last, w_sc, w_done;
  logic            w_unused;
  assign w_unused = ^{rd_wen_i, inst_i[24:15]};
  assign w_opc   = inst_i[6:0];
  assign w_f3    = inst_i[14:12];
  assign w_f7    = inst_i[31:25];
  assign w_is_op = w_opc == 7'b0110011;
  assign w_is_m  = (M_EN != 0) && w_is_op && w_f7 == 7'b0000001;
  assign w_sub   = w_is_op & inst_i[30];
  assign w_sh    = op2_i[SW-1:0];
  assign w_sra   = XLEN'($signed(op1_i) >>> w_sh);
  assign w_eq    = op1_i == op2_i;
  assign w_lt    = $signed(op1_i) < $signed(op2_i);
  assign w_ltu   = op1_i < op2_i;
  // funct3 bit 0 inverts the base compare (BNE/BGE/BGEU); 010/011 are not branches
  assign w_take  = w_f3[2] ? ((w_f3[1] ? w_ltu : w_lt) ^ w_f3[0]) : (!w_f3[1] & (w_eq ^ w_f3[0]));
  assign w_bimm  = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign w_pc4   = inst_addr_i + XLEN'(4);
  assign w_jalr  = op1_i + op2_i;
  always_comb begin
    case (w_f3)
      3'b000:  w_alu = w_sub ? op1_i - op2_i : op1_i + op2_i;
      3'b001:  w_alu = op1_i << w_sh;
      3'b010:  w_alu = XLEN'(w_lt);
      3'b011:  w_alu = XLEN'(w_ltu);
      3'b100:  w_alu = op1_i ^ op2_i;
      3'b101:  w_alu = inst_i[30] ? w_sra : op1_i >> w_sh;
      3'b110:  w_alu = op1_i | op2_i;
      default: w_alu = op1_i & op2_i;
    endcase
  end
  always_comb begin
    w_wen   = 1'b0;
    w_data  = '0;
    w_jen   = 1'b0;
    w_jaddr = '0;
    case (w_opc)
      7'b0110011: if (w_f7 != 7'b0000001) begin w_wen = 1'b1; w_data = w_alu; end
      7'b0010011: begin w_wen = 1'b1; w_data = w_alu; end
      7'b0110111: begin w_wen = 1'b1; w_data = op1_i; end
      7'b0010111: begin w_wen = 1'b1; w_data = inst_addr_i + op1_i; end
      7'b1101111: begin w_wen = 1'b1; w_data = w_pc4; w_jen = 1'b1; w_jaddr = inst_addr_i + op1_i; end
      7'b1100111: begin w_wen = 1'b1; w_data = w_pc4; w_jen = 1'b1; w_jaddr = {w_jalr[XLEN-1:1], 1'b0}; end
      7'b1100011: begin w_jen = w_take; w_jaddr = w_take ? inst_addr_i + w_bimm : '0; end
      default: ;
    endcase
  end
  // Signed operands: MULH/MULHSU/DIV/REM for rs1, MULH/DIV/REM for rs2
  assign w_s1   = w_f3[2] ? !w_f3[0] : (w_f3[1] ^ w_f3[0]);
  assign w_s2   = (w_f3 == 3'b001) | (w_f3[2] & !w_f3[0]);
  assign w_n1   = w_s1 & op1_i[XLEN-1];
  assign w_n2   = w_s2 & op2_i[XLEN-1];
  assign w_m1   = w_n1 ? -op1_i : op1_i;
  assign w_m2   = w_n2 ? -op2_i : op2_i;
  assign w_rneg = (w_f3[2] & w_f3[1]) ? w_n1 : w_n1 ^ w_n2;
  assign w_dz   = w_f3[2] & (op2_i == '0);
  assign w_ovf  = w_f3[2] & !w_f3[0] & (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&op2_i);
  assign w_spec = w_dz ? (w_f3[1] ? op1_i : '1) : (w_f3[1] ? '0 : op1_i);
  assign w_mstep = r_acc + r_a * W2'(r_b[MUL_BITS-1:0]);
  // Division keeps {remainder, dividend/quotient} in r_acc; r_b holds the divisor
  assign w_dsh   = r_acc[W2-1:XLEN-1];
  assign w_dsub  = w_dsh - {1'b0, r_b};
  assign w_dstep = w_dsub[XLEN] ? {w_dsh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                : {w_dsub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_acc_n = r_f3[2] ? w_dstep : w_mstep;
  assign w_p     = r_neg ? -w_acc_n : w_acc_n;
  assign w_v     = r_f3[1] ? w_acc_n[W2-1:XLEN] : w_acc_n[XLEN-1:0];
  assign w_fin   = r_f3[2] ? (r_neg ? -w_v : w_v) : (r_f3 == 3'b000 ? w_p[XLEN-1:0] : w_p[W2-1:XLEN]);
  assign w_last  = r_f3[2] ? (r_cnt == SW'(XLEN-1)) : (r_cnt == SW'(XLEN/MUL_BITS-1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_f3    <= '0;
      r_neg   <= 1'b0;
      r_rd    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_is_m) begin
          r_f3  <= w_f3;
          r_neg <= w_rneg;
          r_rd  <= rd_addr_i;
          r_cnt <= '0;
          r_acc <= w_f3[2] ? {{XLEN{1'b0}}, w_m1} : '0;
          r_a   <= {{XLEN{1'b0}}, w_m1};
          r_b   <= w_m2;
          r_res <= w_spec;
          r_state <= (w_dz | w_ovf) ? DONE : BUSY;
        end
        BUSY: begin
          r_acc <= w_acc_n;
          r_a   <= r_f3[2] ? r_a : r_a << MUL_BITS;
          r_b   <= r_f3[2] ? r_b : r_b >> MUL_BITS;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_res   <= w_fin;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign w_sc        = rst_n && r_state == IDLE && !w_is_m;
  assign w_done      = rst_n && r_state == DONE;
  assign rd_wen_o    = w_done ? (r_rd != 5'd0) : (w_sc && w_wen && rd_addr_i != 5'd0);
  assign rd_addr_o   = w_done ? r_rd : ((w_sc && w_wen) ? rd_addr_i : 5'd0);
  assign rd_data_o   = w_done ? r_res : (w_sc ? w_data : '0);
  assign jump_en_o   = w_sc && w_jen;
  assign jump_addr_o = w_sc ? w_jaddr : '0;
  assign hold_flag_o = rst_n && (r_state == BUSY || (r_state == IDLE && w_is_m));
endmodule
